fondo_fb_writer: RTL and testbench

- Write-side counterpart of the LCD background image path: a command-driven writer that fills a 1-bit-per-pixel, XY-addressed frame buffer RAM.
- The LCD display path reads the same RAM through its other port, using address {fila, columna}.
- Commands from the control logic: single pixel, horizontal span, full-screen clear.
- Each command is turned into a stream of one-word-per-cycle RAM write strobes.

---
 rtl/fondo_fb_writer_pkg.sv | 13 +
 rtl/fondo_fb_writer_xy_counter.sv | 38 +++
 rtl/fondo_fb_writer.sv | 86 ++++++++
 tb/tb_fondo_fb_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fondo_fb_writer_pkg.sv
// fondo_fb_writer_pkg: op codes, FSM states and default geometry for the frame buffer writer.
package fondo_fb_writer_pkg;
   localparam int DEF_COL_MAX  = 800;
   localparam int DEF_FILA_MAX = 480;
   typedef enum logic [1:0] {OP_PIXEL = 2'b00, OP_SPAN = 2'b01, OP_CLEAR = 2'b10, OP_RSVD = 2'b11} op_t;
   typedef enum logic [2:0] {S_IDLE, S_PIXEL, S_SPAN, S_CLEAR, S_FIN} state_t;
   function automatic int clogb2(input int v);
      int r;
      r = 0;
      for (int t = v; t > 0; t = t >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/fondo_fb_writer_xy_counter.sv
// fb_xy_counter: loadable column-inner/row-outer scan counter with bounds, enable and last flag.
module fb_xy_counter #(
   parameter int N_COL = 10,
   parameter int N_FIL = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [N_COL-1:0] col_start,
   input  logic [N_COL-1:0] col_end,
   input  logic [N_FIL-1:0] row_start,
   input  logic [N_FIL-1:0] row_end,
   output logic [N_COL-1:0] col,
   output logic [N_FIL-1:0] row,
   output logic             last
);
   logic [N_COL-1:0] col_lo, col_hi;
   logic [N_FIL-1:0] row_hi;
   assign last = col == col_hi && row == row_hi;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col    <= '0;
         row    <= '0;
         col_lo <= '0;
         col_hi <= '0;
         row_hi <= '0;
      end else if (load) begin
         col    <= col_start;
         row    <= row_start;
         col_lo <= col_start;
         col_hi <= col_end;
         row_hi <= row_end;
      end else if (en && !last) begin
         col <= col == col_hi ? col_lo : col + N_COL'(1);
         row <= col == col_hi ? row + N_FIL'(1) : row;
      end
endmodule

// File: rtl/fondo_fb_writer.sv
// fondo_fb_writer: turns pixel/span/clear commands into one-per-cycle 1bpp frame buffer writes.
// Define FB_VBLANK_GATE_EN to restrict writes to cycles with vblank=1.
module fondo_fb_writer
   import fondo_fb_writer_pkg::*;
#(
   parameter int  COL_MAX   = DEF_COL_MAX,
   parameter int  FILA_MAX  = DEF_FILA_MAX,
   localparam int N_COL     = clogb2(COL_MAX - 1),
   localparam int N_FIL     = clogb2(FILA_MAX - 1),
   localparam int ADDR_BITS = N_FIL + N_COL
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [N_COL-1:0]     cmd_x0,
   input  logic [N_COL-1:0]     cmd_x1,
   input  logic [N_FIL-1:0]     cmd_fila,
   input  logic                 cmd_color,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic                 wr_data,
   output logic                 done,
   input  logic                 vblank
);
   localparam logic [N_COL-1:0] COL_LAST = N_COL'(COL_MAX - 1);
   localparam logic [N_FIL-1:0] FIL_LAST = N_FIL'(FILA_MAX - 1);
   state_t           state, state_nx;
   logic             color, go, busy, accept, last, clip;
   logic [N_COL-1:0] lo, hi, col_s, col_e, col;
   logic [N_FIL-1:0] row_s, row_e, row;
`ifdef FB_VBLANK_GATE_EN
   assign go = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign go = 1'b1;
`endif
   assign accept = cmd_valid & cmd_ready;
   assign busy   = state == S_PIXEL || state == S_SPAN || state == S_CLEAR;
   assign lo     = cmd_x0 < cmd_x1 ? cmd_x0 : cmd_x1;
   assign hi     = cmd_x0 < cmd_x1 ? cmd_x1 : cmd_x0;
   // Scan bounds for the command being offered; a clipped command never enters a write state.
   always_comb begin
      col_s = cmd_x0;
      col_e = cmd_x0;
      row_s = cmd_fila;
      row_e = cmd_fila;
      clip  = cmd_x0 > COL_LAST || cmd_fila > FIL_LAST;
      if (cmd_op == OP_SPAN) begin
         col_s = lo;
         col_e = hi > COL_LAST ? COL_LAST : hi;
         clip  = lo > COL_LAST || cmd_fila > FIL_LAST;
      end else if (cmd_op == OP_CLEAR) begin
         col_s = '0;
         col_e = COL_LAST;
         row_s = '0;
         row_e = FIL_LAST;
         clip  = 1'b0;
      end else if (cmd_op == OP_RSVD) clip = 1'b1;
   end
   always_comb begin
      state_nx  = state == S_IDLE ? (!cmd_valid ? S_IDLE : clip ? S_FIN :
                  cmd_op == OP_PIXEL ? S_PIXEL : cmd_op == OP_SPAN ? S_SPAN : S_CLEAR) :
                  !busy ? S_IDLE : (go && last) ? S_FIN : state;
      cmd_ready = state == S_IDLE;
      done      = state == S_FIN;
      wr_en     = busy & go;
      wr_addr   = {row, col};
      wr_data   = color;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= S_IDLE;
         color <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) color <= cmd_op == OP_CLEAR ? 1'b0 : cmd_color;
      end
   fb_xy_counter #(.N_COL(N_COL), .N_FIL(N_FIL)) u_xy (
      .clk(CLK), .rst(RST), .load(accept), .en(busy & go),
      .col_start(col_s), .col_end(col_e), .row_start(row_s), .row_end(row_e),
      .col(col), .row(row), .last(last)
   );
endmodule

// File: tb/tb_fondo_fb_writer.sv
// tb_fondo_fb_writer: randomized self-checking bench with a list-of-writes reference model.
module tb_fondo_fb_writer;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic cmd_valid = 0, cmd_color = 0, vblank = 1;
   logic [1:0] cmd_op = 0;
   logic [9:0] cmd_x0 = 0, cmd_x1 = 0;
   logic [8:0] cmd_fila = 0;
   logic cmd_ready, wr_en, wr_data, done;
   logic [18:0] wr_addr;
   logic s_valid = 0, s_color = 0, s_vblank = 1;
   logic [1:0] s_op = 0;
   logic [4:0] s_x0 = 0, s_x1 = 0;
   logic [3:0] s_fila = 0;
   logic s_ready, s_wr_en, s_wr_data, s_done;
   logic [8:0] s_wr_addr;
   int checks = 0, fails = 0;
   int got_a[$], exp_a[$];
   bit got_d[$], got_v[$];
   int first_w, last_w, done_at, ready_at, ndone;
   bit early, vb_mode = 0;

   fondo_fb_writer dut (
      .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_fila(cmd_fila), .cmd_color(cmd_color),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .vblank(vblank)
   );
   fondo_fb_writer #(.COL_MAX(20), .FILA_MAX(12)) dut_s (
      .CLK(clk), .RST(rst), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(s_op),
      .cmd_x0(s_x0), .cmd_x1(s_x1), .cmd_fila(s_fila), .cmd_color(s_color),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .done(s_done), .vblank(s_vblank)
   );

   // Reference: the set of addresses a command must write, in order, on an 800x480 screen.
   task automatic model(input int op, input int x0, input int x1, input int fila);
      exp_a.delete();
      if (op == 0 && x0 < 800 && fila < 480) exp_a.push_back(fila * 1024 + x0);
      if (op == 1 && fila < 480)
         for (int c = (x0 < x1 ? x0 : x1); c <= (x0 < x1 ? x1 : x0) && c < 800; c++)
            exp_a.push_back(fila * 1024 + c);
   endtask

   task automatic issue(input int op, input int x0, input int x1, input int fila, input bit c,
                        input bit noise, input int limit);
      got_a.delete(); got_d.delete(); got_v.delete();
      first_w = -1; last_w = -1; done_at = -1; ready_at = -1; ndone = 0; early = 0;
      @(negedge clk);
      cmd_op = 2'(op); cmd_x0 = 10'(x0); cmd_x1 = 10'(x1); cmd_fila = 9'(fila); cmd_color = c;
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      cmd_op = 2'($urandom); cmd_x0 = 10'($urandom); cmd_x1 = 10'($urandom);
      cmd_fila = 9'($urandom); cmd_color = 1'($urandom);
      for (int cyc = 1; cyc <= limit && ready_at < 0; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (vb_mode) vblank = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
         cmd_valid = noise && !cmd_ready && $urandom_range(0, 1) == 1;
         #1;
         if (wr_en) begin
            got_a.push_back(int'(wr_addr)); got_d.push_back(wr_data); got_v.push_back(vblank);
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
         end
         if (done) begin ndone++; if (done_at < 0) done_at = cyc; end
         if (cmd_ready) begin
            if (done_at < 0) early = 1;
            else if (ready_at < 0) ready_at = cyc;
         end
      end
      cmd_valid = 0;
      vblank = 1;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
      checks++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      checks++; if (wr_addr !== 19'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", wr_addr); end
      checks++; if (wr_data !== 1'b0) begin fails++; $display("FAIL reset_data: got %b want 0", wr_data); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
   endtask

   task automatic test_pixel;
      issue(0, 5, 0, 3, 1, 0, 50);
      checks++; if (got_a.size() != 1) begin fails++; $display("FAIL pixel_count: got %0d want 1", got_a.size()); end
      checks++; if ((got_a.size() > 0 ? got_a[0] : -1) != 32'h0C05) begin fails++; $display("FAIL pixel_addr: got %0h want c05", got_a.size() > 0 ? got_a[0] : -1); end
      checks++; if ((got_d.size() > 0 ? got_d[0] : 1'b0) !== 1'b1) begin fails++; $display("FAIL pixel_data: got 0 want 1"); end
      checks++; if (first_w != 1) begin fails++; $display("FAIL pixel_first: got %0d want 1", first_w); end
      checks++; if (done_at != 2) begin fails++; $display("FAIL pixel_done: got %0d want 2", done_at); end
      checks++; if (ready_at != 3) begin fails++; $display("FAIL pixel_ready: got %0d want 3", ready_at); end
      checks++; if (ndone != 1 || early) begin fails++; $display("FAIL pixel_hs: got done=%0d early=%0d want 1 0", ndone, early); end
   endtask

   task automatic test_span_reversed;
      int bad;
      issue(1, 12, 10, 479, 1, 0, 50);
      bad = 0;
      for (int k = 0; k < got_a.size(); k++) if (k > 2 || got_a[k] != 479 * 1024 + 10 + k || got_d[k] !== 1'b1) bad++;
      checks++; if (got_a.size() != 3) begin fails++; $display("FAIL span_count: got %0d want 3", got_a.size()); end
      checks++; if (bad != 0) begin fails++; $display("FAIL span_addr: got %0d bad writes want 0", bad); end
      checks++; if (first_w != 1 || last_w != 3) begin fails++; $display("FAIL span_cycles: got %0d..%0d want 1..3", first_w, last_w); end
      checks++; if (done_at != 4 || ready_at != 5) begin fails++; $display("FAIL span_done: got %0d/%0d want 4/5", done_at, ready_at); end
   endtask

   task automatic test_clip_random;
      int t_op[7] = '{1, 0, 1, 1, 1, 3, 0};
      int t_x0[7] = '{790, 800, 3, 1023, 900, 4, 799};
      int t_x1[7] = '{1000, 0, 3, 5, 850, 9, 0};
      int t_f[7]  = '{0, 7, 100, 480, 5, 6, 480};
      int op, x0, x1, f, bad, wd;
      bit c;
      for (int i = 0; i < 37; i++) begin
         if (i < 7) begin op = t_op[i]; x0 = t_x0[i]; x1 = t_x1[i]; f = t_f[i]; end
         else begin
            op = $urandom_range(0, 3); if (op == 2) op = 1;
            x0 = $urandom_range(0, 1023); x1 = $urandom_range(0, 1023); f = $urandom_range(0, 511);
         end
         c = 1'($urandom);
         model(op, x0, x1, f);
         issue(op, x0, x1, f, c, i % 2 == 1, 1500);
         bad = 0;
         for (int k = 0; k < got_a.size() && k < exp_a.size(); k++) if (got_a[k] != exp_a[k] || got_d[k] !== c) bad++;
         wd = exp_a.size() > 0 ? exp_a.size() + 1 : 1;
         checks++; if (got_a.size() != exp_a.size()) begin fails++; $display("FAIL cmd%0d_count: got %0d want %0d", i, got_a.size(), exp_a.size()); end
         checks++; if (bad != 0) begin fails++; $display("FAIL cmd%0d_writes: got %0d bad want 0", i, bad); end
         checks++; if (done_at != wd) begin fails++; $display("FAIL cmd%0d_done: got %0d want %0d", i, done_at, wd); end
         checks++; if (ready_at != wd + 1 || ndone != 1 || early) begin fails++; $display("FAIL cmd%0d_ready: got %0d n=%0d e=%0d want %0d 1 0", i, ready_at, ndone, early, wd + 1); end
      end
   endtask

   task automatic test_clear_small;
      int n, bad, pad, sd, sr, nd, extra, last_a;
      bit ones;
      exp_a.delete();
      for (int r = 0; r < 12; r++) for (int col = 0; col < 20; col++) exp_a.push_back(r * 32 + col);
      @(negedge clk);
      s_op = 2; s_color = 1; s_x0 = 5'($urandom); s_fila = 4'($urandom); s_valid = 1;
      @(negedge clk);
      s_valid = 0;
      n = 0; bad = 0; pad = 0; sd = -1; sr = -1; nd = 0; ones = 0; last_a = -1;
      for (int cyc = 1; cyc <= 400 && sr < 0; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (!s_ready) begin
            s_valid = $urandom_range(0, 1) == 1; s_op = 0; s_x0 = 5'($urandom_range(0, 19));
            s_fila = 4'($urandom_range(0, 11)); s_color = 1;
         end else s_valid = 0;
         if (s_wr_en) begin
            if (n >= exp_a.size() || int'(s_wr_addr) != exp_a[n]) bad++;
            if (s_wr_data) ones = 1;
            if (s_wr_addr[4:0] >= 5'd20) pad++;
            last_a = int'(s_wr_addr);
            n++;
         end
         if (s_done) begin nd++; if (sd < 0) sd = cyc; end
         if (s_ready && sd >= 0) sr = cyc;
      end
      s_valid = 0;
      extra = 0;
      repeat (5) begin @(negedge clk); if (s_wr_en) extra++; end
      checks++; if (n != 240) begin fails++; $display("FAIL clear_count: got %0d want 240", n); end
      checks++; if (bad != 0) begin fails++; $display("FAIL clear_order: got %0d bad want 0", bad); end
      checks++; if (ones) begin fails++; $display("FAIL clear_data: got 1 want 0"); end
      checks++; if (pad != 0) begin fails++; $display("FAIL clear_padding: got %0d want 0", pad); end
      checks++; if (last_a != 11 * 32 + 19) begin fails++; $display("FAIL clear_last: got %0h want %0h", last_a, 11 * 32 + 19); end
      checks++; if (sd != 241 || sr != 242 || nd != 1) begin fails++; $display("FAIL clear_done: got %0d/%0d n=%0d want 241/242 1", sd, sr, nd); end
      checks++; if (extra != 0) begin fails++; $display("FAIL clear_queued: got %0d writes want 0", extra); end
   endtask

   task automatic test_reset_mid_clear;
      int k, bad;
      @(negedge clk);
      cmd_op = 2; cmd_color = 1; cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      k = 0; bad = 0;
      for (int cyc = 0; cyc < 3000 && k < 1000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (wr_en) begin
            if (wr_addr !== 19'((k / 800) * 1024 + k % 800) || wr_data !== 1'b0) bad++;
            k++;
         end
      end
      checks++; if (k != 1000) begin fails++; $display("FAIL abort_reach: got %0d writes want 1000", k); end
      checks++; if (bad != 0) begin fails++; $display("FAIL abort_order: got %0d bad want 0", bad); end
      #2 rst = 1;
      #1;
      checks++; if (wr_en !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort_async: got wr_en=%b done=%b want 0 0", wr_en, done); end
      @(negedge clk);
      rst = 0;
      #1;
      checks++; if (cmd_ready !== 1'b1 || wr_en !== 1'b0) begin fails++; $display("FAIL abort_idle: got ready=%b wr_en=%b want 1 0", cmd_ready, wr_en); end
      issue(0, 7, 0, 9, 0, 0, 50);
      checks++; if (got_a.size() != 1 || got_a[0] != 9 * 1024 + 7 || got_d[0] !== 1'b0) begin fails++; $display("FAIL abort_pixel: got %0d writes want 1 at %0h", got_a.size(), 9 * 1024 + 7); end
      checks++; if (done_at != 2 || ready_at != 3) begin fails++; $display("FAIL abort_pixel_done: got %0d/%0d want 2/3", done_at, ready_at); end
   endtask

   task automatic test_vblank;
      int bad, off;
      vb_mode = 1;
      issue(1, 0, 7, 2, 1, 0, 100);
      vb_mode = 0;
      bad = 0; off = 0;
      for (int k = 0; k < got_a.size(); k++) begin
         if (k > 7 || got_a[k] != 2 * 1024 + k) bad++;
         if (!got_v[k]) off++;
      end
      checks++; if (got_a.size() != 8) begin fails++; $display("FAIL vblank_count: got %0d want 8", got_a.size()); end
      checks++; if (bad != 0) begin fails++; $display("FAIL vblank_order: got %0d bad want 0", bad); end
`ifdef FB_VBLANK_GATE_EN
      checks++; if (off != 0) begin fails++; $display("FAIL vblank_gate: got %0d writes outside vblank want 0", off); end
      checks++; if (last_w != 16 || done_at != 17) begin fails++; $display("FAIL vblank_timing: got %0d/%0d want 16/17", last_w, done_at); end
`else
      checks++; if (first_w != 1 || last_w != 8 || done_at != 9) begin fails++; $display("FAIL vblank_ignored: got %0d..%0d done %0d want 1..8 done 9", first_w, last_w, done_at); end
`endif
   endtask

   initial begin
      test_reset;
      test_pixel;
      test_span_reversed;
      test_clip_random;
      test_clear_small;
      test_reset_mid_clear;
      test_vblank;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
